// File: rtl/serial_tx_pkg.sv
// Shared state encoding and default word width for the serial pattern transmitter.
package serial_tx_pkg;

  localparam int SERIAL_TX_DATA_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register: load has priority over shift, LSB shifts out first.
module piso_shift_reg #(
  parameter int DATA_W = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_lsb
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {1'b0, r_data[DATA_W-1:1]};
    end
  end

  assign o_lsb = r_data[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// Word-to-bitstream transmitter (LSB first, one bit per clock).
// Define SERIAL_TX_GAP_EN to insert GAP_CYCLES quiet cycles after every word.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W     = SERIAL_TX_DATA_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

`ifdef SERIAL_TX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(DATA_W);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_next;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_lsb;

  piso_shift_reg #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_lsb   (w_lsb)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_gap_cnt <= w_gap_next;
    end
  end

  assign w_last = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);

  // The bit counter parks on its last value between words and restarts only on a reload.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap_cnt;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt != LAST_BIT) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end else if (GAP_EN) begin
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end else if (load_valid) begin
          w_load     = 1'b1;
          w_shift    = 1'b0;
          w_cnt_next = '0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          w_state_next = ST_IDLE;
        end else begin
          w_gap_next = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Every output is a pure decode of flops, so load_valid never reaches load_ready combinationally.
  assign load_ready = (r_state == ST_IDLE) || (w_last && !GAP_EN);
  assign x_valid    = (r_state == ST_SHIFT);
  assign x          = w_lsb && (r_state == ST_SHIFT);
  assign busy       = (r_state != ST_IDLE);
  assign done       = w_last;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: occupancy-based reference model plus a bit-stream monitor.
module tb_serial_pattern_tx;

  localparam int DW = 20;
  localparam int GC = 2;
`ifdef SERIAL_TX_GAP_EN
  localparam int GAP_LEN = GC;
`else
  localparam int GAP_LEN = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          done;

  serial_pattern_tx #(
    .DATA_W     (DW),
    .GAP_CYCLES (GC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   m_rem      = 0;   // cycles of occupancy left, counting the current one
  int   words_sent = 0;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic exp_ready();
    return (m_rem == 0) || (GAP_LEN == 0 && m_rem == 1);
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d);
    @(negedge clock);
    check1("load_ready", load_ready, exp_ready());
    check1("busy", busy, m_rem > 0);
    check1("x_valid_window", x_valid, m_rem > GAP_LEN);
    load_valid = v;
    load_data  = d;
    @(posedge clock);
    if (v && exp_ready()) begin
      for (int k = 0; k < DW; k++) exp_q.push_back('{b: d[k], last: (k == DW - 1)});
      m_rem = DW + GAP_LEN;
      words_sent++;
      $display("TX word %0d accepted data=%05h t=%0t", words_sent, d, $time);
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    int n0;
    n0 = words_sent;
    for (int g = 0; g < 100 && words_sent == n0; g++) step(1'b1, w);
    checks++;
    if (words_sent == n0) begin
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && m_rem > 0; i++) step(1'b0, DW'($urandom));
    step(1'b0, '0);
    step(1'b0, '0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_bits_pending required=0", exp_q.size());
    end
  endtask

  // Monitor: every cycle with x_valid must carry the next expected bit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (x_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit actual=x_valid required=idle t=%0t", $time);
        end else begin
          checks--;
          e = exp_q.pop_front();
          check1("x_bit", x, e.b);
          check1("done", done, e.last);
        end
      end else begin
        check1("idle_x", x, 1'b0);
        check1("idle_done", done, 1'b0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check1("rst_load_ready", load_ready, 1'b1);
    check1("rst_x", x, 1'b0);
    check1("rst_x_valid", x_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    reset = 1'b1;

    // Reference word, then a held second word that must follow without a gap.
    send(20'b11101011011011011111);
    send(20'h00001);
    drain();

    // Back-to-back random words.
    for (int i = 0; i < 3; i++) send(DW'($urandom));
    drain();

    // Reset in the middle of a word, while hammering load_valid/load_data.
    send(DW'($urandom));
    repeat (7) step(1'b1, DW'($urandom));
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_rem = 0;
    check1("midrst_x", x, 1'b0);
    check1("midrst_x_valid", x_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_load_ready", load_ready, 1'b1);
    load_valid = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b1;
    send(20'hFFFFF);
    drain();

    // Random traffic with data changing every cycle.
    for (int i = 0; i < 1200; i++) step(($urandom_range(0, 2) != 0), DW'($urandom));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
